// File: rtl/mdu_e.sv
// Execute-stage multiply/divide unit holding architectural HI/LO.
// Define MDU_MADD_EN to enable MDUOp 7 as signed multiply-accumulate (madd).
module mdu_e #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic [2:0]  MDUOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Busy,
   output logic        StallReq,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);

   localparam logic [2:0] OpMult  = 3'd1;
   localparam logic [2:0] OpMultu = 3'd2;
   localparam logic [2:0] OpDiv   = 3'd3;
   localparam logic [2:0] OpDivu  = 3'd4;
   localparam logic [2:0] OpMthi  = 3'd5;
   localparam logic [2:0] OpMtlo  = 3'd6;
   localparam logic [2:0] OpMadd  = 3'd7;

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            busy_q;
   logic [2:0]      op_q;
   logic [31:0]     a_q, b_q, hi_q, lo_q;

   logic            is_long, is_mul, free, accept, commit;
   logic [63:0]     a_sx, b_sx, prod_s, prod_u, madd_sum;
   logic            div_signed;
   logic [31:0]     a_mag, b_mag, b_div, quo_mag, rem_mag, quo, rem;
   logic [31:0]     res_hi, res_lo;
   logic            res_we;

   always_comb begin
      is_long = (MDUOp >= OpMult) && (MDUOp <= OpDivu);
      is_mul  = (MDUOp == OpMult) || (MDUOp == OpMultu);
`ifdef MDU_MADD_EN
      if (MDUOp == OpMadd) begin
         is_long = 1'b1;
         is_mul  = 1'b1;
      end
`endif
   end

   // The completion edge is also an accept edge so back-to-back ops lose no cycle.
   assign free   = (cnt_q == '0) || (cnt_q == CntW'(1));
   assign accept = Start && free && is_long;
   assign commit = (cnt_q == CntW'(1));

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
      if (accept)      cnt_d = is_mul ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
   end

   assign a_sx     = {{32{a_q[31]}}, a_q};
   assign b_sx     = {{32{b_q[31]}}, b_q};
   assign prod_s   = a_sx * b_sx;
   assign prod_u   = {32'd0, a_q} * {32'd0, b_q};
   assign madd_sum = {hi_q, lo_q} + prod_s;

   // Signed division on magnitudes sidesteps the 0x80000000 / -1 overflow corner.
   always_comb begin
      div_signed = (op_q == OpDiv);
      a_mag      = (div_signed && a_q[31]) ? -a_q : a_q;
      b_mag      = (div_signed && b_q[31]) ? -b_q : b_q;
      b_div      = (b_q == '0) ? 32'd1 : b_mag;
      quo_mag    = a_mag / b_div;
      rem_mag    = a_mag % b_div;
      quo        = (div_signed && (a_q[31] ^ b_q[31])) ? -quo_mag : quo_mag;
      rem        = (div_signed && a_q[31]) ? -rem_mag : rem_mag;
   end

   always_comb begin
      res_hi = hi_q;
      res_lo = lo_q;
      res_we = 1'b0;
      case (op_q)
         OpMult:  begin {res_hi, res_lo} = prod_s; res_we = 1'b1; end
         OpMultu: begin {res_hi, res_lo} = prod_u; res_we = 1'b1; end
         OpDiv, OpDivu: begin
            res_hi = rem;
            res_lo = quo;
            res_we = (b_q != '0);
         end
         OpMadd:  begin {res_hi, res_lo} = madd_sum; res_we = 1'b1; end
         default: res_we = 1'b0;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= (cnt_d != '0);
         if (accept) begin
            op_q <= MDUOp;
            a_q  <= A;
            b_q  <= B;
         end
         if (commit && res_we) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
         end
         // A move issued on the completion edge is younger than the finishing op.
         if (Start && free && (MDUOp == OpMthi)) hi_q <= A;
         if (Start && free && (MDUOp == OpMtlo)) lo_q <= A;
      end
   end

   assign Busy     = busy_q;
   assign StallReq = busy_q || (Start && is_long);
   assign HI       = hi_q;
   assign LO       = lo_q;

endmodule

// File: tb/tb_mdu_e.sv
// Randomized self-checking bench for mdu_e against a cycle-indexed behavioural model.
module tb_mdu_e;

   localparam int unsigned MultN = 5;
   localparam int unsigned DivN  = 10;

   logic        Clk = 1'b0;
   logic        Reset, Start;
   logic [2:0]  MDUOp;
   logic [31:0] A, B;
   logic        Busy, StallReq;
   logic [31:0] HI, LO;

   mdu_e #(.MULT_CYCLES(MultN), .DIV_CYCLES(DivN)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .MDUOp(MDUOp), .A(A), .B(B),
      .Busy(Busy), .StallReq(StallReq), .HI(HI), .LO(LO)
   );

   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: an op accepted at edge e completes at edge done_at = e + latency.
   logic [31:0] m_hi, m_lo, m_a, m_b;
   logic [2:0]  m_op;
   longint      edge_n  = 0;
   longint      done_at = 0;
   bit          m_pend  = 0;
   bit          m_in_rst = 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   function automatic bit long_op(input logic [2:0] op);
`ifdef MDU_MADD_EN
      return (op >= 3'd1 && op <= 3'd4) || op == 3'd7;
`else
      return op >= 3'd1 && op <= 3'd4;
`endif
   endfunction

   function automatic bit m_busy();
      return edge_n < done_at;
   endfunction

   task automatic m_commit();
      longint sa, sb;
      longint unsigned ua, ub, acc;
      sa = longint'($signed(m_a));
      sb = longint'($signed(m_b));
      ua = {32'd0, m_a};
      ub = {32'd0, m_b};
      case (m_op)
         3'd1: begin acc = sa * sb; {m_hi, m_lo} = acc; end
         3'd2: begin acc = ua * ub; {m_hi, m_lo} = acc; end
         3'd3: if (m_b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
         3'd4: if (m_b != 0) begin m_lo = 32'(ua / ub); m_hi = 32'(ua % ub); end
         3'd7: begin acc = {m_hi, m_lo} + longint'(sa * sb); {m_hi, m_lo} = acc; end
         default: ;
      endcase
   endtask

   task automatic m_edge(input bit s, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
      longint e;
      e = edge_n + 1;
      if (!m_in_rst) begin
         if (m_pend && e == done_at) begin
            m_commit();
            m_pend = 0;
         end
         if (s && e >= done_at) begin
            if (long_op(op)) begin
               m_op = op; m_a = a; m_b = b; m_pend = 1;
               done_at = e + ((op == 3'd3 || op == 3'd4) ? longint'(DivN) : longint'(MultN));
            end else if (op == 3'd5) m_hi = a;
            else if (op == 3'd6) m_lo = a;
         end
      end
      edge_n = e;
   endtask

   // Called at a negedge; drives one cycle and checks outputs after the posedge.
   task automatic cyc(input bit s, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b);
      Start = s; MDUOp = op; A = a; B = b;
      #1;
      check("stall", {63'd0, StallReq}, {63'd0, m_busy() | (s & long_op(op))});
      @(posedge Clk);
      m_edge(s, op, a, b);
      #1;
      check("busy", {63'd0, Busy}, {63'd0, m_busy()});
      check("hi", {32'd0, HI}, {32'd0, m_hi});
      check("lo", {32'd0, LO}, {32'd0, m_lo});
      @(negedge Clk);
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int busy_len);
      cyc(1'b1, op, a, b);
      busy_len = 0;
      while (Busy && busy_len < 40) begin
         busy_len++;
         cyc(1'b0, 3'd0, $urandom, $urandom);
      end
      check("drain_timeout", {63'd0, Busy}, 64'd0);
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int len;
      bit s;
      logic [2:0] op;
      Reset = 1'b0; Start = 1'b0; MDUOp = 3'd0; A = '0; B = '0;
      m_hi = '0; m_lo = '0; m_a = '0; m_b = '0; m_op = '0;
      repeat (3) @(negedge Clk);
      check("rst_busy", {63'd0, Busy}, 64'd0);
      check("rst_hilo", {HI, LO}, 64'd0);
      Reset = 1'b1;
      m_in_rst = 0;

      // Asynchronous reset in the middle of a mult
      cyc(1'b1, 3'd5, 32'h1234, 0);
      cyc(1'b1, 3'd6, 32'h5678, 0);
      cyc(1'b1, 3'd1, 32'd9, 32'd9);
      cyc(1'b0, 3'd0, 0, 0);
      cyc(1'b0, 3'd0, 0, 0);
      #2 Reset = 1'b0;
      #1;
      check("rst_mid_busy", {63'd0, Busy}, 64'd0);
      check("rst_mid_hilo", {HI, LO}, 64'd0);
      m_hi = '0; m_lo = '0; m_pend = 0; done_at = 0; m_in_rst = 1;
      @(negedge Clk);
      Reset = 1'b1;
      m_in_rst = 0;
      repeat (8) cyc(1'b0, 3'd0, 0, 0);
      check("rst_after_hilo", {HI, LO}, 64'd0);

      run_op(3'd1, 32'hFFFF_FFFE, 32'd3, len);
      check("mult_len", 64'(len), 64'(MultN));
      check("mult_res", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
      run_op(3'd2, 32'hFFFF_FFFE, 32'd3, len);
      check("multu_res", {HI, LO}, 64'h0000_0002_FFFF_FFFA);

      run_op(3'd3, 32'hFFFF_FFF9, 32'd2, len);
      check("div_len", 64'(len), 64'(DivN));
      check("div_res", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);

      cyc(1'b1, 3'd5, 32'h11, 0);
      cyc(1'b1, 3'd6, 32'h22, 0);
      run_op(3'd4, 32'd7, 32'd0, len);
      check("div0_len", 64'(len), 64'(DivN));
      check("div0_res", {HI, LO}, 64'h0000_0011_0000_0022);

      run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, len);
      check("div_ovf", {HI, LO}, 64'h0000_0000_8000_0000);

      // Starts while busy are ignored; back-to-back accept on the completion edge
      cyc(1'b1, 3'd1, 32'd6, 32'd7);
      cyc(1'b0, 3'd0, 0, 0);
      cyc(1'b1, 3'd5, 32'h55, 32'd3);
      cyc(1'b1, 3'd3, 32'd100, 32'd3);
      cyc(1'b0, 3'd0, 0, 0);
      cyc(1'b1, 3'd1, 32'd3, 32'd4);
      check("b2b_res", {HI, LO}, 64'd42);
      check("b2b_busy", {63'd0, Busy}, 64'd1);
      while (Busy && edge_n < 100000) cyc(1'b0, 3'd0, 0, 0);
      check("b2b_res2", {HI, LO}, 64'd12);

      // Operands toggled while busy
      cyc(1'b1, 3'd2, 32'h0001_2345, 32'h0000_0777);
      for (int i = 0; i < int'(MultN) - 1; i++) cyc(1'b0, 3'd0, ~A, ~B);
      cyc(1'b0, 3'd0, 0, 0);
      check("toggle_res", {HI, LO}, 64'h0001_2345 * 64'h0000_0777);
      check("toggle_stall", {63'd0, StallReq}, 64'd0);

      cyc(1'b1, 3'd6, 32'd10, 0);
      cyc(1'b1, 3'd5, 32'd0, 0);
      run_op(3'd7, 32'hFFFF_FFFF, 32'd5, len);
`ifdef MDU_MADD_EN
      check("madd_res", {HI, LO}, 64'd5);
`else
      check("op7_len", 64'(len), 64'd0);
      check("op7_res", {HI, LO}, 64'd10);
`endif

      for (int i = 0; i < 600; i++) begin
         if (edge_n + 1 < done_at) begin
            s  = ($urandom_range(0, 3) == 0);
            op = 3'($urandom_range(0, 7));
         end else if (m_pend && edge_n + 1 == done_at) begin
            s  = $urandom_range(0, 1) == 1;
            op = 3'($urandom_range(0, 4));
         end else begin
            s  = ($urandom_range(0, 2) != 0);
            op = 3'($urandom_range(0, 7));
         end
         cyc(s, op, pick_val(), pick_val());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mdu_e.md
Name: mdu_e

Overview:
- Execute-stage multiply/divide unit that sits beside the ALU, ahead of the E/M pipeline register.
- It runs multi-cycle MIPS mult/multu/div/divu and single-cycle mthi/mtlo, and holds the architectural HI/LO registers.
- It exports Busy so the D-stage stall logic can hold any MDU-class instruction while an operation is in flight.
- HI/LO are read combinationally by the E-stage result mux for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, number of cycles Busy stays high for mult/multu (≥1).
- DIV_CYCLES, 10, number of cycles Busy stays high for div/divu (≥1).

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Reset  input  1  asynchronous, active-low reset (0 = reset).
- Start  input  1  qualifies MDUOp for the current cycle; driven only for a valid, non-flushed E-stage instruction.
- MDUOp  input  3  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (see Optional Feature).
- A  input  32  rs operand, already forwarded.
- B  input  32  rt operand, already forwarded.
- Busy  output  1  a multi-cycle operation is in flight.
- StallReq  output  1  Busy | (Start & MDUOp in 1..4); combinational, used by hazard logic.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Reset (Reset=0, any time, asynchronous):
  - HI=0, LO=0, Busy=0, internal counter=0, captured operands=0.
  - An in-flight operation is discarded; HI/LO are not updated afterwards.
- Accept rule: at a posedge with Start=1, Busy=0 and MDUOp in 1..4:
  - Capture A, B and MDUOp.
  - Load the counter with MULT_CYCLES (ops 1, 2) or DIV_CYCLES (ops 3, 4).
- Busy = (counter != 0), driven registered.
- Counter decrements on every posedge while nonzero.
- On the edge where the counter goes 1→0, HI/LO take the result and Busy falls on that same edge.
- Timing: for a start accepted at edge t, Busy=1 during the N cycles following edge t. New HI/LO are visible after edge t+N, and a new start can be accepted at edge t+N.
- Start while Busy=1, any MDUOp: ignored completely. Hazard logic must never do this; the bench checks that state is untouched.
- mthi (5) / mtlo (6) with Start=1 and Busy=0: HI (resp. LO) ← A at that edge. Busy stays 0. The other register is unchanged.
- MDUOp 0, or Start=0: no effect.
- mult: {HI,LO} = signed(A) × signed(B), full 64-bit product.
- multu: {HI,LO} = unsigned 64-bit product.
- div: LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero (B=0, div or divu): still busy for DIV_CYCLES; HI/LO left unchanged at completion.
- Results use only the operands captured at accept. Changes on A/B during Busy have no effect.
- HI/LO outputs hold their old values throughout Busy.
- Arithmetic may be computed combinationally from the captured operands. Only the commit timing is specified.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: MDUOp 7 = madd, signed. {HI,LO} ← {HI,LO} + signed(A)×signed(B), modulo 2^64. It uses MULT_CYCLES latency and the same accept/commit rules, and accumulates onto the HI/LO value present at commit.
- Undefined: MDUOp 7 is treated as op 0, with no state change and no Busy.

Test Plan:
- Reset=0 mid-mult (start, then reset low after 2 cycles, release) → Busy=0, HI=LO=0 immediately, and both stay 0 past the original completion time.
- mult A=0xFFFFFFFE(−2), B=3 → Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9(−7), B=2 → Busy 10 cycles; LO=0xFFFFFFFD(−3), HI=0xFFFFFFFF(−1). divu A=7, B=0 after mthi 0x11 / mtlo 0x22 → HI=0x11, LO=0x22 unchanged after 10 busy cycles.
- Start mult 6×7 at t; at t+2 present Start=1 with mthi A=0x55 and div operands → both ignored; result HI=0, LO=42 at t+5. At edge t+5 a new mult is accepted back-to-back.
- Operands changed during Busy (A/B toggled every cycle) → result equals the product of the values captured at accept. StallReq is 1 on the accept cycle and throughout Busy, and 0 afterwards.
- With MDU_MADD_EN: mtlo 10, mthi 0, then madd A=0xFFFFFFFF, B=5 → HI=0, LO=5. Without the macro the same op leaves HI=0, LO=10 and Busy stays 0.
